// File: rtl/fll_if_pkg.sv
// fll_if_pkg
// Shared definitions for the APB-to-FLL configuration bridge.
//   - fll_state_e   : handshake FSM states (IDLE, REQ, RELEASE)
//   - FLL_REG0..3   : word offsets (PADDR[4:2]) mapped onto FLL registers
//   - STATUS_OFFS   : word offset of the local STATUS register
//   - STAT_*_BIT    : bit positions inside STATUS
//   - FLL_WRN_RST   : idle/reset level of fll_wrn_o (1 = read, CFGWEB polarity)
package fll_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } fll_state_e;

    localparam logic [2:0] FLL_REG0    = 3'd0;
    localparam logic [2:0] FLL_REG1    = 3'd1;
    localparam logic [2:0] FLL_REG2    = 3'd2;
    localparam logic [2:0] FLL_REG3    = 3'd3;
    localparam logic [2:0] STATUS_OFFS = 3'd4;

    localparam int STAT_LOCK_BIT = 0;
    localparam int STAT_TMO_BIT  = 1;
    localparam int STAT_LOST_BIT = 2;

    localparam logic FLL_WRN_RST = 1'b1;

    // True when the word offset selects one of the four FLL registers.
    function automatic logic is_fll_offs(input logic [2:0] offs);
        return offs inside {FLL_REG0, FLL_REG1, FLL_REG2, FLL_REG3};
    endfunction

endpackage

// File: rtl/fll_lock_sync.sv
// fll_lock_sync
// Two-flop synchroniser for the FLL lock indication plus a falling-edge
// detector on the synchronised value.
//   clk_i        in   peripheral clock
//   rstn_i       in   asynchronous active-low reset
//   lock_i       in   raw lock, asynchronous to clk_i
//   lock_sync_o  out  synchronised lock (reset 0)
//   lock_fall_o  out  high for one cycle when lock_sync_o goes 1 -> 0
module fll_lock_sync (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic lock_i,
    output logic lock_sync_o,
    output logic lock_fall_o
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = lock_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lock_sync_o = sync_q;
    // prev_q is the synchronised value one cycle older, so this is a clean
    // single-cycle pulse that never looks at the metastable stage.
    assign lock_fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/apb_fll_if.sv
// apb_fll_if
// APB slave translating register accesses into the FLL configuration
// request/acknowledge handshake, with a bus timeout, a synchronised lock
// status and sticky error flags.
//   APB side : PADDR/PWDATA/PWRITE/PSEL/PENABLE in, PRDATA/PREADY/PSLVERR out
//   FLL side : fll_req_o/fll_wrn_o/fll_add_o/fll_data_o out,
//              fll_ack_i/fll_r_data_i/fll_lock_i in
//   irq_o    : one-cycle lock-loss interrupt pulse
// Offsets (PADDR[4:2]): 0..3 FLL registers, 4 STATUS, 5..7 error response.
// Optional macro FLL_LOCK_IRQ_EN: enables lock-loss sticky (STATUS[2]) and
// irq_o; when undefined irq_o is 0 and STATUS[2] reads 0.
module apb_fll_if
    import fll_if_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      fll_req_o,
    output logic                      fll_wrn_o,
    output logic [1:0]                fll_add_o,
    output logic [31:0]               fll_data_o,
    input  logic                      fll_ack_i,
    input  logic [31:0]               fll_r_data_i,
    input  logic                      fll_lock_i,
    output logic                      irq_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    fll_state_e        state_q, state_d;
    logic              wrn_q, wrn_d;
    logic [1:0]        add_q, add_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_sticky_q, tmo_sticky_d;

    logic [2:0]  offs;
    logic        access;
    logic        tmo_hit;
    logic        tmo_set;
    logic [2:0]  w1c;
    logic        lock_sync;
    logic        lock_fall;
    logic        lost_bit;
    logic [31:0] status_word;

    fll_lock_sync u_lock_sync (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .lock_i      (fll_lock_i),
        .lock_sync_o (lock_sync),
        .lock_fall_o (lock_fall)
    );

    assign offs    = PADDR[4:2];
    assign access  = PSEL & PENABLE;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        status_word                = '0;
        status_word[STAT_LOCK_BIT] = lock_sync;
        status_word[STAT_TMO_BIT]  = tmo_sticky_q;
        status_word[STAT_LOST_BIT] = lost_bit;
    end

    always_comb begin
        state_d   = state_q;
        wrn_d     = wrn_q;
        add_d     = add_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        fll_req_o = 1'b0;
        tmo_set   = 1'b0;
        w1c       = 3'b000;

        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (is_fll_offs(offs)) begin
                        // A previous aborted handshake may still hold ack high;
                        // the new request is only launched once ack drops.
                        if (!fll_ack_i) begin
                            wrn_d   = ~PWRITE;
                            add_d   = offs[1:0];
                            data_d  = PWDATA;
                            rdata_d = '0;
                            cnt_d   = '0;
                            state_d = ST_REQ;
                        end
                    end else begin
                        PREADY = 1'b1;
                        if (offs == STATUS_OFFS) begin
                            PRDATA = status_word;
                            if (PWRITE) begin
                                w1c = PWDATA[2:0];
                            end
                        end else begin
                            PSLVERR = 1'b1;
                        end
                    end
                end
            end

            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (tmo_hit) begin
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                    tmo_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fll_req_o = 1'b1;
                    if (fll_ack_i) begin
                        if (wrn_q) begin
                            rdata_d = fll_r_data_i;
                        end
                        state_d = ST_RELEASE;
                    end
                end
            end

            ST_RELEASE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!fll_ack_i) begin
                    PREADY  = 1'b1;
                    PRDATA  = rdata_q;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                    tmo_set = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Set beats clear when both happen in the same cycle.
        tmo_sticky_d = (tmo_sticky_q & ~w1c[STAT_TMO_BIT]) | tmo_set;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            wrn_q        <= FLL_WRN_RST;
            add_q        <= '0;
            data_q       <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            tmo_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wrn_q        <= wrn_d;
            add_q        <= add_d;
            data_q       <= data_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            tmo_sticky_q <= tmo_sticky_d;
        end
    end

`ifdef FLL_LOCK_IRQ_EN
    logic lost_sticky_q, lost_sticky_d;
    logic irq_q, irq_d;

    always_comb begin
        lost_sticky_d = (lost_sticky_q & ~w1c[STAT_LOST_BIT]) | lock_fall;
        irq_d         = lock_fall;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lost_sticky_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            lost_sticky_q <= lost_sticky_d;
            irq_q         <= irq_d;
        end
    end

    assign lost_bit = lost_sticky_q;
    assign irq_o    = irq_q;
`else
    logic unused_lock;
    assign unused_lock = lock_fall ^ w1c[STAT_LOST_BIT];
    assign lost_bit    = 1'b0;
    assign irq_o       = 1'b0;
`endif

    assign fll_wrn_o  = wrn_q;
    assign fll_add_o  = add_q;
    assign fll_data_o = data_q;

    // Only PADDR[4:2] participate in decoding.
    logic unused_paddr;
    assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

endmodule

// File: tb/tb_apb_fll_if.sv
// tb_apb_fll_if
// Randomised and directed APB traffic against apb_fll_if with a scoreboard.
// The stimulus side predicts each APB response from an abstract model (FLL
// register contents, sticky flags, lock level, expected wait states) and
// queues it; a monitor pops and compares on every completed transfer.
module tb_apb_fll_if;

    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        fll_req_o;
    logic        fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_ack_i;
    logic [31:0] fll_r_data_i;
    logic        fll_lock_i;
    logic        irq_o;

    apb_fll_if #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PWRITE       (PWRITE),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .fll_req_o    (fll_req_o),
        .fll_wrn_o    (fll_wrn_o),
        .fll_add_o    (fll_add_o),
        .fll_data_o   (fll_data_o),
        .fll_ack_i    (fll_ack_i),
        .fll_r_data_i (fll_r_data_i),
        .fll_lock_i   (fll_lock_i),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // FLL peripheral model: 0 = ack looped from req, 1 = ack stuck low,
    // 2 = ack is req delayed by one clock.
    int          ack_mode = 0;
    logic        ack_dly;
    logic [31:0] fllmem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) ack_dly <= 1'b0;
        else         ack_dly <= fll_req_o;
    end

    always @(posedge clk_i) begin
        if (fll_req_o && fll_ack_i && !fll_wrn_o) fllmem[fll_add_o] <= fll_data_o;
    end

    assign fll_ack_i    = (ack_mode == 0) ? fll_req_o : (ack_mode == 2) ? ack_dly : 1'b0;
    assign fll_r_data_i = fllmem[fll_add_o];

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        slverr;
        int          waits;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Abstract reference state
    logic [31:0] shadow [4];
    logic        m_lock = 1'b0;
    logic        m_tmo  = 1'b0;
    logic        m_lost = 1'b0;

    logic        exp_fll_active = 1'b0;
    logic        exp_wrn;
    logic [1:0]  exp_add;
    logic [31:0] exp_data;
    int          irq_hi_cnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        int   wait_cnt;
        exp_t e;
        wait_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (irq_o === 1'b1) irq_hi_cnt++;
            if (!rstn_i || !(PSEL && PENABLE)) begin
                wait_cnt = 0;
            end else if (PREADY) begin
                if (sb.size() == 0) begin
                    check32("unexpected_pready", 32'(PREADY), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check32({e.tag, "_pslverr"}, 32'(PSLVERR), 32'(e.slverr));
                    check32({e.tag, "_waits"}, wait_cnt, e.waits);
                    if (e.chk_rdata) check32({e.tag, "_prdata"}, PRDATA, e.rdata);
                    $display("[TB] xfer %s addr=0x%03h wr=%0b waits=%0d prdata=0x%08h pslverr=%0b",
                             e.tag, PADDR, PWRITE, wait_cnt, PRDATA, PSLVERR);
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            if (rstn_i) begin
                if (exp_fll_active) begin
                    if (fll_req_o) begin
                        check32("fll_wrn", 32'(fll_wrn_o), 32'(exp_wrn));
                        check32("fll_add", 32'(fll_add_o), 32'(exp_add));
                        if (!exp_wrn) check32("fll_data", fll_data_o, exp_data);
                    end
                end else begin
                    check32("req_idle", 32'(fll_req_o), 32'd0);
                end
            end
        end
    end

    task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wd);
        logic done;
        done = 1'b0;
        @(posedge clk_i); #1;
        PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk_i); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (PREADY) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check32("pready_bound", 32'(PREADY), 32'd1);
            void'(sb.pop_front());
        end
        @(posedge clk_i); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                           input string tag);
        exp_t       e;
        logic [2:0] offs;
        offs        = addr[4:2];
        e.tag       = tag;
        e.rdata     = '0;
        e.chk_rdata = !wr;
        e.slverr    = 1'b0;
        e.waits     = 0;
        if (offs < 3'd4) begin
            exp_wrn        = !wr;
            exp_add        = offs[1:0];
            exp_data       = wd;
            exp_fll_active = 1'b1;
            if (ack_mode == 1) begin
                e.slverr    = 1'b1;
                e.chk_rdata = 1'b1;
                e.waits     = TMO;
                m_tmo       = 1'b1;
            end else begin
                e.waits = (ack_mode == 0) ? 2 : 4;
                if (wr) shadow[offs[1:0]] = wd;
                else    e.rdata = shadow[offs[1:0]];
            end
        end else if (offs == 3'd4) begin
            e.rdata = {29'd0, m_lost, m_tmo, m_lock};
            if (wr) begin
                if (wd[1]) m_tmo  = 1'b0;
                if (wd[2]) m_lost = 1'b0;
            end
        end else begin
            e.slverr    = 1'b1;
            e.chk_rdata = 1'b1;
        end
        sb.push_back(e);
        apb_xfer(addr, wr, wd);
        exp_fll_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [2:0] offs;
        logic [6:0] hi;
        logic       irq_en;
`ifdef FLL_LOCK_IRQ_EN
        irq_en = 1'b1;
`else
        irq_en = 1'b0;
`endif
        for (int i = 0; i < 4; i++) shadow[i] = 32'h0;
        rstn_i = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        fll_lock_i = 1'b0;
        #23;
        check32("rst_pready",  32'(PREADY),  32'd0);
        check32("rst_pslverr", 32'(PSLVERR), 32'd0);
        check32("rst_prdata",  PRDATA,       32'd0);
        check32("rst_req",     32'(fll_req_o), 32'd0);
        check32("rst_wrn",     32'(fll_wrn_o), 32'd1);
        check32("rst_add",     32'(fll_add_o), 32'd0);
        check32("rst_data",    fll_data_o,   32'd0);
        check32("rst_irq",     32'(irq_o),   32'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;

        // Random traffic with well-behaved acknowledges
        for (int n = 0; n < 40; n++) begin
            ack_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            offs     = 3'($urandom_range(0, 7));
            hi       = 7'($urandom_range(0, 127));
            do_xfer({hi, offs, 2'b00}, 1'($urandom_range(0, 1)), $urandom, "rand");
        end

        // Directed FLL write and read
        ack_mode = 0;
        do_xfer(12'h004, 1'b1, 32'h0000_1234, "fll_wr");
        do_xfer(12'h00C, 1'b1, 32'hCAFE_F00D, "fll_wr3");
        do_xfer(12'h00C, 1'b0, 32'h0, "fll_rd3");
        do_xfer(12'h004, 1'b0, 32'h0, "fll_rd1");

        // Timeout with ack stuck low, then STATUS and W1C
        ack_mode = 1;
        do_xfer(12'h008, 1'b1, 32'h5555_AAAA, "timeout");
        ack_mode = 0;
        do_xfer(12'h010, 1'b0, 32'h0, "stat_tmo");
        do_xfer(12'h010, 1'b1, 32'h0000_0002, "stat_w1c");
        do_xfer(12'h010, 1'b0, 32'h0, "stat_clr");

        // Invalid offset
        do_xfer(12'h018, 1'b0, 32'h0, "invalid");
        do_xfer(12'h01C, 1'b1, 32'hFFFF_FFFF, "invalid_wr");

        // Reset in the middle of REQ with ack held low
        ack_mode = 1;
        exp_wrn = 1'b0; exp_add = 2'd2; exp_data = 32'h0BAD_0BAD; exp_fll_active = 1'b1;
        @(posedge clk_i); #1;
        PADDR = 12'h008; PWRITE = 1'b1; PWDATA = 32'h0BAD_0BAD; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk_i); #1;
        PENABLE = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check32("req_before_rst", 32'(fll_req_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check32("req_async_rst", 32'(fll_req_o), 32'd0);
        check32("wrn_async_rst", 32'(fll_wrn_o), 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0; exp_fll_active = 1'b0;
        m_tmo = 1'b0; m_lost = 1'b0;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        ack_mode = 0;
        do_xfer(12'h008, 1'b1, 32'h1357_9BDF, "post_rst_wr");
        do_xfer(12'h008, 1'b0, 32'h0, "post_rst_rd");

        // Lock synchronisation and lock-loss interrupt
        @(posedge clk_i); #1;
        fll_lock_i = 1'b1; m_lock = 1'b1;
        repeat (3) @(posedge clk_i);
        do_xfer(12'h010, 1'b0, 32'h0, "stat_lock");
        base = irq_hi_cnt;
        @(posedge clk_i); #1;
        fll_lock_i = 1'b0; m_lock = 1'b0;
        if (irq_en) m_lost = 1'b1;
        repeat (8) @(posedge clk_i);
        #1;
        check32("irq_cycles", irq_hi_cnt - base, irq_en ? 32'd1 : 32'd0);
        do_xfer(12'h010, 1'b0, 32'h0, "stat_lost");
        do_xfer(12'h010, 1'b1, 32'h0000_0004, "stat_w1c_lost");
        do_xfer(12'h010, 1'b0, 32'h0, "stat_final");

        repeat (2) @(posedge clk_i);
        check32("sb_drained", sb.size(), 32'd0);
        check32("irq_total", irq_hi_cnt, irq_en ? 32'd1 : 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
